// File: rtl/gestor_color_cubos.sv
// rtl/gestor_color_cubos.sv - two-stage cube colour selector with blink, priority, colour table and overlap counter
module gestor_color_cubos #(
  parameter int                     N_CUBOS          = 5,
  parameter int                     ANCHO_COLOR      = 8,
  parameter logic [ANCHO_COLOR-1:0] COLOR_FONDO      = 8'hFF,
  parameter int                     PERIODO_PARPADEO = 30,
  localparam int                    IDX_W            = (N_CUBOS > 1) ? $clog2(N_CUBOS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CUBOS-1:0]     estado_cubos,
  input  logic                   pixel_valido,
  input  logic                   inicio_cuadro,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [ANCHO_COLOR-1:0] wr_color,
  input  logic [N_CUBOS-1:0]     parpadeo_en,
  output logic [ANCHO_COLOR-1:0] color_seleccionado,
  output logic                   color_valido,
  output logic                   colision,
  output logic [15:0]            colisiones_cuadro
);

  localparam int CW = (PERIODO_PARPADEO > 1) ? $clog2(PERIODO_PARPADEO) : 1;

  logic [CW-1:0]          contador_cuadros;
  logic                   fase;
  logic [15:0]            contador;
  logic [ANCHO_COLOR-1:0] tabla [N_CUBOS];

  logic [N_CUBOS-1:0] visibles;
  logic [IDX_W-1:0]   ganador;
  logic               colision_ahora;

  logic               valido_r;
  logic               hay_cubo_r;
  logic [IDX_W-1:0]   ganador_r;
  logic               colision_r;

  // Blinking cubes drop out of the vector so lower-priority cubes show through.
  always_comb begin
    visibles       = estado_cubos & ~(parpadeo_en & {N_CUBOS{fase}});
    colision_ahora = pixel_valido && ((visibles & (visibles - N_CUBOS'(1))) != '0);
    ganador        = '0;
    for (int i = N_CUBOS - 1; i >= 0; i--) begin
      if (visibles[i]) ganador = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      contador_cuadros <= '0;
      fase             <= 1'b0;
    end else if (inicio_cuadro) begin
      if (contador_cuadros == CW'(PERIODO_PARPADEO - 1)) begin
        contador_cuadros <= '0;
        fase             <= ~fase;
      end else begin
        contador_cuadros <= contador_cuadros + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CUBOS; i++) tabla[i] <= COLOR_FONDO;
    end else if (wr_en && (int'(wr_idx) < N_CUBOS)) begin
      tabla[wr_idx] <= wr_color;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valido_r   <= 1'b0;
      hay_cubo_r <= 1'b0;
      ganador_r  <= '0;
      colision_r <= 1'b0;
    end else begin
      valido_r   <= pixel_valido;
      hay_cubo_r <= (visibles != '0);
      ganador_r  <= ganador;
      colision_r <= colision_ahora;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_seleccionado <= '0;
      color_valido       <= 1'b0;
      colision           <= 1'b0;
    end else begin
      color_valido <= valido_r;
      colision     <= colision_r;
      if (!valido_r)       color_seleccionado <= '0;
      else if (hay_cubo_r) color_seleccionado <= tabla[ganador_r];
      else                 color_seleccionado <= COLOR_FONDO;
    end
  end

  // A colliding pixel on the frame-start cycle belongs to the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      contador          <= '0;
      colisiones_cuadro <= '0;
    end else if (inicio_cuadro) begin
      colisiones_cuadro <= contador;
      contador          <= {15'd0, colision_ahora};
    end else if (colision_ahora && (contador != 16'hFFFF)) begin
      contador <= contador + 16'd1;
    end
  end

endmodule
